// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/div into private HI/LO, plus mthi/mtlo.
// The result is computed at start and held pending; busy models the multi-cycle latency.
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDUOP,
   input  logic [31:0] ARI1_E,
   input  logic [31:0] ARI2_E,
   input  logic        HISel,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOUT_E
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        pend_hi_q, pend_hi_d;
   logic [31:0]        pend_lo_q, pend_lo_d;
   logic               pend_wr_q, pend_wr_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic               busy_q, busy_d;

   logic               is_signed, a_neg, b_neg, div_zero;
   logic [63:0]        a_ext, b_ext, prod;
   logic [31:0]        a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

   // Sign-magnitude datapath: one multiplier and one unsigned divider serve both signednesses
   always_comb begin
      is_signed = (MDUOP == OP_MULT) || (MDUOP == OP_DIV);
      a_neg     = is_signed & ARI1_E[31];
      b_neg     = is_signed & ARI2_E[31];
      a_ext     = {{32{a_neg}}, ARI1_E};
      b_ext     = {{32{b_neg}}, ARI2_E};
      prod      = a_ext * b_ext;
      a_mag     = a_neg ? (~ARI1_E + 32'd1) : ARI1_E;
      b_mag     = b_neg ? (~ARI2_E + 32'd1) : ARI2_E;
      div_zero  = (ARI2_E == 32'd0);
      b_div     = div_zero ? 32'd1 : b_mag;
      q_mag     = a_mag / b_div;
      r_mag     = a_mag % b_div;
      quot      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      rem       = a_neg ? (~r_mag + 32'd1) : r_mag;
   end

   // Next-state and register updates
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (MDUOP)
                  OP_MULT, OP_MULTU: begin
                     pend_hi_d = prod[63:32];
                     pend_lo_d = prod[31:0];
                     pend_wr_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = S_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_hi_d = rem;
                     pend_lo_d = quot;
                     pend_wr_d = ~div_zero;
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     state_d   = S_DIV;
                  end
                  OP_MTHI: hi_d = ARI1_E;
                  OP_MTLO: lo_d = ARI1_E;
                  default: ;
               endcase
            end
         end
         S_MUL, S_DIV: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // A divide by zero still burns its cycles but leaves HI/LO alone
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign HI       = hi_q;
   assign LO       = lo_q;
   assign MDUOUT_E = HISel ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: an arithmetic reference model checked every cycle,
// plus hand-computed HI/LO/busy-length expectations.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  MDUOP = 3'd0;
   logic [31:0] ARI1_E = 32'd0;
   logic [31:0] ARI2_E = 32'd0;
   logic        HISel = 1'b0;
   logic        busy;
   logic [31:0] HI, LO, MDUOUT_E;

   int n_checks = 0;
   int n_fail   = 0;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .MDUOP(MDUOP),
      .ARI1_E(ARI1_E), .ARI2_E(ARI2_E), .HISel(HISel),
      .busy(busy), .HI(HI), .LO(LO), .MDUOUT_E(MDUOUT_E)
   );

   always #5 clk = ~clk;

   // Reference model: result computed from plain signed/unsigned arithmetic,
   // made visible at the edge start_cycle + latency.
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
   logic        m_busy = 1'b0, m_wr = 1'b0;
   int          cyc = 0, m_done = 0;

   always @(posedge clk or negedge reset) begin
      longint          sq, sr;
      longint unsigned up;
      if (!reset) begin
         m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0;
      end else begin
         cyc++;
         if (m_busy) begin
            if (cyc == m_done) begin
               if (m_wr) begin m_hi = m_phi; m_lo = m_plo; end
               m_busy = 1'b0;
            end
         end else if (start) begin
            case (MDUOP)
               3'd1: begin
                  sq = longint'($signed(ARI1_E)) * longint'($signed(ARI2_E));
                  m_phi = sq[63:32]; m_plo = sq[31:0];
                  m_wr = 1'b1; m_busy = 1'b1; m_done = cyc + 5;
               end
               3'd2: begin
                  up = 64'(ARI1_E) * 64'(ARI2_E);
                  m_phi = up[63:32]; m_plo = up[31:0];
                  m_wr = 1'b1; m_busy = 1'b1; m_done = cyc + 5;
               end
               3'd3, 3'd4: begin
                  m_wr = (ARI2_E != 32'd0);
                  if (m_wr) begin
                     if (MDUOP == 3'd3) begin
                        sq = longint'($signed(ARI1_E)) / longint'($signed(ARI2_E));
                        sr = longint'($signed(ARI1_E)) % longint'($signed(ARI2_E));
                     end else begin
                        sq = longint'(ARI1_E) / longint'(ARI2_E);
                        sr = longint'(ARI1_E) % longint'(ARI2_E);
                     end
                     m_plo = sq[31:0]; m_phi = sr[31:0];
                  end
                  m_busy = 1'b1; m_done = cyc + 10;
               end
               3'd5: m_hi = ARI1_E;
               3'd6: m_lo = ARI1_E;
               default: ;
            endcase
         end
      end
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Cycle-by-cycle comparison against the model, sampled mid-cycle
   always @(negedge clk) begin
      check32("model busy", 32'(busy), 32'(m_busy));
      check32("model HI", HI, m_hi);
      check32("model LO", LO, m_lo);
      check32("model MDUOUT_E", MDUOUT_E, HISel ? m_hi : m_lo);
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; MDUOP = op; ARI1_E = a; ARI2_E = b;
      @(negedge clk);
      start = 1'b0; MDUOP = 3'd0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) begin
         n_checks++; n_fail++;
         $display("FAIL busy timeout: still busy after %0d cycles, expected idle", n);
      end
   endtask

   initial begin
      int n;
      #1;
      check32("reset HI", HI, 32'd0);
      check32("reset LO", LO, 32'd0);
      check32("reset busy", 32'(busy), 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;

      issue(3'd1, 32'hFFFF_FFFF, 32'd2);
      wait_idle(n);
      check32("mult busy len", 32'(n), 32'd5);
      check32("mult HI", HI, 32'hFFFF_FFFF);
      check32("mult LO", LO, 32'hFFFF_FFFE);

      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(n);
      check32("multu HI", HI, 32'hFFFF_FFFE);
      check32("multu LO", LO, 32'h0000_0001);

      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      check32("div busy len", 32'(n), 32'd10);
      check32("div LO", LO, 32'hFFFF_FFFD);
      check32("div HI", HI, 32'hFFFF_FFFF);

      issue(3'd4, 32'd7, 32'd2);
      wait_idle(n);
      check32("divu LO", LO, 32'd3);
      check32("divu HI", HI, 32'd1);

      issue(3'd5, 32'h1234_5678, 32'd0);
      issue(3'd6, 32'h9ABC_DEF0, 32'd0);
      check32("mtxx busy", 32'(busy), 32'd0);
      HISel = 1'b1; #1;
      check32("mfhi", MDUOUT_E, 32'h1234_5678);
      HISel = 1'b0; #1;
      check32("mflo", MDUOUT_E, 32'h9ABC_DEF0);
      @(negedge clk);

      issue(3'd3, 32'd5, 32'd0);
      wait_idle(n);
      check32("div0 busy len", 32'(n), 32'd10);
      check32("div0 HI", HI, 32'h1234_5678);
      check32("div0 LO", LO, 32'h9ABC_DEF0);

      issue(3'd1, 32'h0001_0000, 32'h0001_0000);
      @(negedge clk);
      issue(3'd5, 32'hDEAD_BEEF, 32'd0);
      wait_idle(n);
      check32("ignored mthi HI", HI, 32'd1);
      check32("ignored mthi LO", LO, 32'd0);

      issue(3'd3, 32'd100, 32'd7);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check32("abort busy", 32'(busy), 32'd0);
      check32("abort HI", HI, 32'd0);
      check32("abort LO", LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (15) @(negedge clk);
      check32("no commit HI", HI, 32'd0);
      check32("no commit LO", LO, 32'd0);

      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      check32("ovf LO", LO, 32'h8000_0000);
      check32("ovf HI", HI, 32'd0);

      issue(3'd1, 32'd6, 32'd7);
      wait_idle(n);
      check32("b2b mult LO", LO, 32'd42);
      issue(3'd3, 32'd100, 32'd7);
      wait_idle(n);
      check32("b2b commit gap", 32'(n + 1), 32'd11);
      check32("b2b div LO", LO, 32'd14);
      check32("b2b div HI", HI, 32'd2);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the E stage of the five-stage pipeline. It sits beside the E-stage ALU and takes the same forwarded operands (ARI1_E, ARI2_E). It runs multi-cycle signed and unsigned multiply and divide into private HI/LO registers, and serves mfhi/mflo/mthi/mtlo. It asserts `busy` so the hazard unit can stall any multiply/divide-class instruction in D until the operation finishes.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu.
- DIV_CYCLES, 10: busy cycles for div/divu.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle strobe from the E controller; starts the operation given by MDUOP.
- MDUOP  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- ARI1_E  input  32  forwarded rs operand; dividend / multiplicand / mthi-mtlo data.
- ARI2_E  input  32  forwarded rt operand; divisor / multiplier.
- HISel  input  1  1 = MDUOUT_E shows HI, 0 = shows LO (mfhi/mflo).
- busy  output  1  high while an operation is in progress.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- MDUOUT_E  output  32  HISel ? HI : LO, combinational; carried to the M register in place of ALUOUT_E for mfhi/mflo.

## Operation
- States: IDLE, MUL, DIV.
- IDLE, start=1:
  - MDUOP 1/2: latch the full 64-bit product into pend_hi/pend_lo. Load cnt=MULT_CYCLES. Go to MUL.
  - MDUOP 3/4: latch the quotient into pend_lo and the remainder into pend_hi. Load cnt=DIV_CYCLES. Go to DIV.
  - MDUOP 5/6: write ARI1_E into HI or LO at this edge. Stay in IDLE; busy stays 0.
  - MDUOP 0/7: no effect.
- MUL/DIV: decrement cnt each edge. On the edge where cnt goes 1→0, commit pend_hi→HI and pend_lo→LO, then go to IDLE.
- start while in MUL/DIV: ignored, including mthi/mtlo. The hazard unit guarantees this never happens; the block is still defined to ignore it.
- Signed (mult, div) ops treat operands as two's complement. Unsigned ops (multu, divu) zero-extend.
- Division rounds toward zero; the remainder takes the dividend's sign.
- Divide by zero: the operation runs the full DIV_CYCLES, but HI/LO are not updated at commit.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- HI/LO never change mid-operation. Reads during busy return the old values; the hazard unit prevents such reads.

## Timing
- Reset (asynchronous, while reset=0): HI=0, LO=0, busy=0, state IDLE, cnt=0, pend_hi=pend_lo=0. Output values are visible immediately, without waiting for a clock.
- start sampled at edge E0:
  - busy=1 from just after E0 until just after edge E0+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO hold new values from just after E0+N.
  - busy=0 in the cycle that follows.
- busy is registered, with no combinational path from start. The hazard unit must combine start|busy itself.
- A new start is accepted in the first cycle with busy=0, giving back-to-back throughput of one operation per N+1 cycles.
- mthi/mtlo latency: one edge. The value is readable via MDUOUT_E in the next cycle.
- Reset asserted mid-operation aborts it. HI/LO return to 0 and the pending result is discarded.
- MDUOUT_E and HI/LO are combinational from registers only.

## Test plan
- Reset, then check values → HI=LO=0, busy=0. Pulse start, MDUOP=1, ARI1_E=0xFFFFFFFF, ARI2_E=2 → busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with 0xFFFFFFFF × 0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div with -7 / 2 → after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu with 7 / 2 → LO=3, HI=1.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles → busy stays 0; HISel=1 gives MDUOUT_E=0x12345678, HISel=0 gives 0x9ABCDEF0. Then div with 5 / 0 → busy 10 cycles, HI/LO unchanged.
- Start mult, then at cycle 2 pulse start with MDUOP=5 → it is ignored; after commit HI/LO hold the product. Start div, then drive reset low at cycle 4 → busy=0, HI=LO=0 immediately; after release, no commit occurs.
- div with 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Back-to-back mult then div → second start accepted in the cycle busy falls; div result appears 11 cycles after the mult commit.
